// File: rtl/pwm.sv
// rtl/pwm.sv - single-channel PWM generator with a 256-slot period and glitch-free duty update.
// Optional period_start strobe port is enabled by defining PWM_PERIOD_STROBE_EN.
module pwm #(
    parameter int CLK_FREQ_HZ   = 12000000,
    parameter int PWM_PERIOD_US = 20000
) (
    output logic       out,
    input  logic       clk,
    input  logic [7:0] duty,
    input  logic       en,
    input  logic       rst_n
`ifdef PWM_PERIOD_STROBE_EN
    ,
    output logic       period_start
`endif
);

    localparam int PERIOD_TICKS = CLK_FREQ_HZ / 1000000 * PWM_PERIOD_US;
    localparam int SLOT_TICKS   = PERIOD_TICKS / 256;
    localparam int PRE_W        = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SLOT_TICKS - 1);

    generate
        if (SLOT_TICKS < 1) begin : g_bad_period
            $error("pwm: period shorter than 256 clocks, SLOT_TICKS must be >= 1");
        end
    endgenerate

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]       slot_cnt_q, slot_cnt_d;
    logic [7:0]       duty_q, duty_d;
    logic             out_q, out_d;
    logic             at_start;
    logic [7:0]       duty_eff;

    // The compare uses the value being latched at a period start, so the first
    // cycle of a period already reflects the new duty (no one-clock stale pulse).
    always_comb begin
        at_start   = (pre_cnt_q == '0) && (slot_cnt_q == 8'd0);
        duty_eff   = at_start ? duty : duty_q;
        pre_cnt_d  = pre_cnt_q;
        slot_cnt_d = slot_cnt_q;
        duty_d     = duty_q;
        out_d      = 1'b0;
        if (!en) begin
            pre_cnt_d  = '0;
            slot_cnt_d = 8'd0;
            duty_d     = duty;
        end else begin
            if (pre_cnt_q == PRE_LAST) begin
                pre_cnt_d  = '0;
                slot_cnt_d = slot_cnt_q + 8'd1;
            end else begin
                pre_cnt_d  = pre_cnt_q + PRE_W'(1);
            end
            if (at_start) begin
                duty_d = duty;
            end
            out_d = (slot_cnt_q < duty_eff);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q  <= '0;
            slot_cnt_q <= 8'd0;
            duty_q     <= 8'd0;
            out_q      <= 1'b0;
        end else begin
            pre_cnt_q  <= pre_cnt_d;
            slot_cnt_q <= slot_cnt_d;
            duty_q     <= duty_d;
            out_q      <= out_d;
        end
    end

    assign out = out_q;

`ifdef PWM_PERIOD_STROBE_EN
    logic strobe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= en & at_start;
        end
    end

    assign period_start = strobe_q;
`endif

endmodule

// File: tb/tb_pwm.sv
// tb/tb_pwm.sv - directed self-checking bench for pwm (512-clock period plus a default-parameter instance).
module tb_pwm;

    logic       clk;
    logic       rst_n;
    logic [7:0] duty;
    logic       en;
    logic       out_s;
    logic [7:0] duty_def;
    logic       en_def;
    logic       out_def;
`ifdef PWM_PERIOD_STROBE_EN
    logic       ps;
    logic       ps_def;
`endif

    int checks = 0;
    int errors = 0;

    pwm #(.CLK_FREQ_HZ(1000000), .PWM_PERIOD_US(512)) u_dut (
        .out   (out_s),
        .clk   (clk),
        .duty  (duty),
        .en    (en),
        .rst_n (rst_n)
`ifdef PWM_PERIOD_STROBE_EN
        ,
        .period_start (ps)
`endif
    );

    pwm u_def (
        .out   (out_def),
        .clk   (clk),
        .duty  (duty_def),
        .en    (en_def),
        .rst_n (rst_n)
`ifdef PWM_PERIOD_STROBE_EN
        ,
        .period_start (ps_def)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output at sample m of a 512-clock period (2 clocks per slot).
    function automatic logic exp_out(input int m, input int d);
        return ((m % 512) / 2) < d;
    endfunction

    task automatic start_en(input logic [7:0] d);
        @(negedge clk);
        en   = 1'b0;
        duty = d;
        @(negedge clk);
        en   = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; duty = 8'd0; en_def = 1'b0; duty_def = 8'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_s !== 1'b0) begin errors++; $display("FAIL reset_out: got %b want 0", out_s); end
`ifdef PWM_PERIOD_STROBE_EN
        checks++;
        if (ps !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", ps); end
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_s !== 1'b0) begin errors++; $display("FAIL idle_out: got %b want 0", out_s); end
    endtask

    task automatic test_duty64;
        int mis = 0;
        int hi = 0;
        start_en(8'd64);
        for (int m = 0; m < 1024; m++) begin
            @(negedge clk);
            if (out_s !== exp_out(m, 64)) mis++;
            if (m < 512 && out_s === 1'b1) hi++;
        end
        checks++;
        if (hi != 128) begin errors++; $display("FAIL duty64_high: got %0d want 128", hi); end
        checks++;
        if (mis != 0) begin errors++; $display("FAIL duty64_pattern: got %0d mismatches want 0", mis); end
    endtask

    task automatic test_duty_bounds;
        int hi = 0;
        int mis = 0;
        start_en(8'd0);
        for (int m = 0; m < 1536; m++) begin
            @(negedge clk);
            if (out_s === 1'b1) hi++;
        end
        checks++;
        if (hi != 0) begin errors++; $display("FAIL duty0_high: got %0d want 0", hi); end
        hi = 0;
        start_en(8'd255);
        for (int m = 0; m < 1024; m++) begin
            @(negedge clk);
            if (out_s !== exp_out(m, 255)) mis++;
            if (m < 512 && out_s === 1'b1) hi++;
        end
        checks++;
        if (hi != 510) begin errors++; $display("FAIL duty255_high: got %0d want 510", hi); end
        checks++;
        if (mis != 0) begin errors++; $display("FAIL duty255_pattern: got %0d mismatches want 0", mis); end
    endtask

    task automatic test_duty_change;
        int mis = 0;
        int hi0 = 0;
        int hi1 = 0;
        start_en(8'd32);
        for (int m = 0; m < 1024; m++) begin
            @(negedge clk);
            if (out_s !== exp_out(m, (m < 512) ? 32 : 96)) mis++;
            if (out_s === 1'b1) begin
                if (m < 512) hi0++; else hi1++;
            end
            if (m == 99) duty = 8'd96;
        end
        checks++;
        if (hi0 != 64) begin errors++; $display("FAIL change_cur_high: got %0d want 64", hi0); end
        checks++;
        if (hi1 != 192) begin errors++; $display("FAIL change_next_high: got %0d want 192", hi1); end
        checks++;
        if (mis != 0) begin errors++; $display("FAIL change_pattern: got %0d mismatches want 0", mis); end
    endtask

    task automatic test_en_drop;
        int hi = 0;
        int mis = 0;
        start_en(8'd128);
        for (int m = 0; m < 50; m++) begin
            @(negedge clk);
            if (out_s === 1'b1) hi++;
            if (m == 49) en = 1'b0;
        end
        checks++;
        if (hi != 50) begin errors++; $display("FAIL drop_pre_high: got %0d want 50", hi); end
        @(negedge clk);
        checks++;
        if (out_s !== 1'b0) begin errors++; $display("FAIL drop_out: got %b want 0", out_s); end
        hi = 0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        for (int m = 0; m < 512; m++) begin
            @(negedge clk);
            if (out_s !== exp_out(m, 128)) mis++;
            if (out_s === 1'b1) hi++;
        end
        checks++;
        if (hi != 256) begin errors++; $display("FAIL reraise_high: got %0d want 256", hi); end
        checks++;
        if (mis != 0) begin errors++; $display("FAIL reraise_pattern: got %0d mismatches want 0", mis); end
    endtask

    task automatic test_async_reset;
        int hi = 0;
        int mis = 0;
        start_en(8'd64);
        repeat (20) @(negedge clk);
        checks++;
        if (out_s !== 1'b1) begin errors++; $display("FAIL pre_reset_out: got %b want 1", out_s); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_s !== 1'b0) begin errors++; $display("FAIL async_reset_out: got %b want 0", out_s); end
        duty = 8'd16;
        en   = 1'b1;
        @(negedge clk);
        checks++;
        if (out_s !== 1'b0) begin errors++; $display("FAIL reset_wins: got %b want 0", out_s); end
        rst_n = 1'b1;
        for (int m = 0; m < 512; m++) begin
            @(negedge clk);
            if (out_s !== exp_out(m, 16)) mis++;
            if (out_s === 1'b1) hi++;
        end
        checks++;
        if (hi != 32) begin errors++; $display("FAIL post_reset_high: got %0d want 32", hi); end
        checks++;
        if (mis != 0) begin errors++; $display("FAIL post_reset_pattern: got %0d mismatches want 0", mis); end
    endtask

`ifdef PWM_PERIOD_STROBE_EN
    task automatic test_strobe;
        int mis = 0;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (ps !== 1'b0) begin errors++; $display("FAIL strobe_idle: got %b want 0", ps); end
        start_en(8'd64);
        for (int m = 0; m < 1024; m++) begin
            @(negedge clk);
            if (ps !== ((m % 512) == 0)) mis++;
            if (ps === 1'b1 && out_s !== 1'b1) mis++;
        end
        checks++;
        if (mis != 0) begin errors++; $display("FAIL strobe_pattern: got %0d mismatches want 0", mis); end
    endtask
`endif

    task automatic test_default_params;
        int hi = 0;
        bit fell = 1'b0;
        @(negedge clk);
        duty_def = 8'd32;
        @(negedge clk);
        en_def = 1'b1;
        for (int m = 0; m < 30100 && !fell; m++) begin
            @(negedge clk);
            if (out_def === 1'b1) hi++;
            else fell = 1'b1;
        end
        checks++;
        if (!fell) begin errors++; $display("FAIL default_fall: got no falling edge within 30100 clocks want fall"); end
        checks++;
        if (hi != 29984) begin errors++; $display("FAIL default_high: got %0d want 29984", hi); end
        en_def = 1'b0;
    endtask

    initial begin
        test_reset();
        test_duty64();
        test_duty_bounds();
        test_duty_change();
        test_en_drop();
        test_async_reset();
`ifdef PWM_PERIOD_STROBE_EN
        test_strobe();
`endif
        test_default_params();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm.md
Name: pwm

Overview:
- Single-channel PWM generator for hobby servos and LED dimming.
- Period is fixed at elaboration from the clock frequency and the requested period in microseconds.
- Pulse width is set by an 8-bit duty input, taken once at the start of each period so the output never glitches.
- Instantiated directly by top-level/test wrappers; the `out` pin drives the servo signal line.

Parameters:
- CLK_FREQ_HZ, 12000000: input clock frequency in Hz.
- PWM_PERIOD_US, 20000: nominal PWM period in microseconds.
- Derived localparam PERIOD_TICKS = CLK_FREQ_HZ/1000000*PWM_PERIOD_US, integer math, truncating.
- Derived localparam SLOT_TICKS = PERIOD_TICKS/256, truncating.
  - Elaboration must fail ($error or equivalent) if SLOT_TICKS < 1.
  - Actual period is 256*SLOT_TICKS clocks; at defaults SLOT_TICKS=937, period=239872 clocks.
- PWM_PERIOD_US must stay a readable parameter of the instance, because callers compute timing from P0.PWM_PERIOD_US.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- out, output, 1: registered PWM output.
- duty, input, 8: requested high time, in units of 1/256 period.
- en, input, 1: enable; low forces idle.
- Positional order for legacy instantiation: out, clk, duty, en, rst_n (rst_n last).

Behaviour:
- Internal state:
  - prescaler pre_cnt, 0..SLOT_TICKS-1;
  - 8-bit slot counter slot_cnt;
  - 8-bit latched duty duty_q;
  - registered out.
- Reset (rst_n=0, async): pre_cnt=0, slot_cnt=0, duty_q=0, out=0. Takes effect immediately, including mid-period; after release the first period starts cleanly as on an enable rise.
- en=0 (synchronous): counters cleared to 0, out=0 on next edge, duty_q loaded with duty every cycle.
- en=1, counting:
  - pre_cnt increments each clock and wraps at SLOT_TICKS-1.
  - On each pre_cnt wrap, slot_cnt increments (8-bit, wraps 255->0).
- Period start is the cycle where pre_cnt=0 and slot_cnt=0. duty_q <= duty is captured only there, or while en=0.
  - Duty changes mid-period take effect at the next period start.
- Output: out <= en & (slot_cnt < duty_q), registered, so one clock latency from the counter state.
  - High time per period = duty_q*SLOT_TICKS clocks, contiguous, beginning at the period start.
  - Low time = (256-duty_q)*SLOT_TICKS clocks.
- Enable rise: first period starts on the first edge with en=1, using duty as sampled while en was low. out first goes high one clock after that edge, if duty>0.
- Boundaries:
  - duty=0: out constantly 0, no pulse.
  - duty=255: high 255/256 of the period; 100% duty is not reachable by design.
  - en falling mid-pulse: out=0 on the next edge, counters cleared.
  - Simultaneous reset and en: reset wins.

Optional Feature:
- Macro: PWM_PERIOD_STROBE_EN.
- When defined: extra output port period_start (1 bit, registered). It pulses high for exactly one clock, aligned with the first out cycle of each period (one clock after the counters reach the period start). It is 0 in reset and while en=0.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
All scenarios use CLK_FREQ_HZ=1000000 and PWM_PERIOD_US=512, so PERIOD_TICKS=512, SLOT_TICKS=2 and the period is 512 clocks.
1. Reset, then en=1 with duty=64 -> out high for exactly 128 clocks, then low for 384, repeating every 512 clocks.
2. duty=0, en=1 for 3 periods -> out stays 0 throughout; duty=255 -> high 510 / low 2 clocks each period.
3. Change duty 32->96 at clock 100 of a period -> current period keeps 64 high clocks; next period has 192.
4. Drop en at clock 50 with duty=128 -> out 0 on the next edge. Re-raise en -> a fresh period starts with 256 high clocks.
5. Assert rst_n=0 mid-pulse -> out drops asynchronously without waiting for clk. After release with en=1, duty=16 -> 32 high clocks starting one clock after the first edge.
6. PWM_PERIOD_STROBE_EN defined -> period_start pulses for 1 clock every 512 clocks, coincident with out rising when duty>0. Default parameters -> measured period 239872 clocks at duty 32 gives 29984 high clocks.
